// File: rtl/vm_multi_vend.sv
// Parametrised vending controller: accumulates coin credit, vends one of
// NUM_PRODUCTS items against per-product stock through a valid/ready
// dispenser handshake, then pays any remaining credit back one change coin
// at a time through a valid/ready hopper handshake.
module vm_multi_vend #(
    parameter int NUM_PRODUCTS = 3,
    parameter int PRICE_W      = 8,
    parameter logic [NUM_PRODUCTS*PRICE_W-1:0] PRICES = {8'd70, 8'd100, 8'd120},
    parameter int COIN_W       = 8,
    parameter int CREDIT_W     = 10,
    parameter int MAX_CREDIT   = 500,
    parameter int CHANGE_UNIT  = 10,
    parameter int STOCK_W      = 4,
    parameter int STOCK_INIT   = 10,
    localparam int SEL_W       = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    coin_valid,
    input  logic [COIN_W-1:0]       coin_value,
    input  logic                    sel_valid,
    input  logic [SEL_W-1:0]        sel_idx,
    input  logic                    cancel,
    input  logic                    restock,
    input  logic                    dispense_ready,
    input  logic                    change_ready,
    output logic                    dispense_valid,
    output logic [SEL_W-1:0]        dispense_idx,
    output logic                    change_valid,
    output logic                    coin_reject,
    output logic                    sel_error,
    output logic [CREDIT_W-1:0]     credit,
    output logic [NUM_PRODUCTS-1:0] stock_empty,
    output logic                    busy
);

    // Arithmetic width wide enough for credit, coin and price plus a carry bit,
    // so the ceiling and affordability compares never wrap.
    localparam int CP_W = (CREDIT_W > COIN_W) ? CREDIT_W : COIN_W;
    localparam int AW   = ((CP_W > PRICE_W) ? CP_W : PRICE_W) + 1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VEND    = 2'd1,
        CHANGE  = 2'd2
    } state_t;

    state_t                    state_reg, state_next;
    logic [CREDIT_W-1:0]       credit_reg, credit_next;
    logic                      dispense_valid_reg, dispense_valid_next;
    logic [SEL_W-1:0]          dispense_idx_reg, dispense_idx_next;
    logic                      change_valid_reg, change_valid_next;
    logic                      coin_reject_reg, coin_reject_next;
    logic                      sel_error_reg, sel_error_next;
    logic                      busy_reg;
    logic [NUM_PRODUCTS-1:0]   stock_empty_reg;
    logic [STOCK_W-1:0]        stock_reg  [NUM_PRODUCTS];
    logic [STOCK_W-1:0]        stock_next [NUM_PRODUCTS];
    logic [NUM_PRODUCTS-1:0]   dec_en;

    logic                      sel_in_range;
    logic [STOCK_W-1:0]        sel_stock;
    logic [AW-1:0]             sel_price;
    logic                      sel_ok;
    logic [AW-1:0]             coin_sum;
    logic                      coin_ok;

    // Look up price and stock of the selected product; out-of-range indices
    // simply leave sel_in_range low.
    always_comb begin
        sel_in_range = 1'b0;
        sel_stock    = '0;
        sel_price    = '0;
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (sel_idx == SEL_W'(i)) begin
                sel_in_range = 1'b1;
                sel_stock    = stock_reg[i];
                sel_price    = AW'(PRICES[i*PRICE_W +: PRICE_W]);
            end
        end
    end

    assign sel_ok   = sel_in_range && (sel_stock != '0) && (AW'(credit_reg) >= sel_price);
    assign coin_sum = AW'(credit_reg) + AW'(coin_value);
    assign coin_ok  = (coin_value != '0) &&
                      ((coin_value % COIN_W'(CHANGE_UNIT)) == '0) &&
                      (coin_sum <= AW'(MAX_CREDIT));

    // Next-state, credit and handshake logic for the three-phase transaction.
    always_comb begin
        state_next          = state_reg;
        credit_next         = credit_reg;
        dispense_valid_next = dispense_valid_reg;
        dispense_idx_next   = dispense_idx_reg;
        change_valid_next   = change_valid_reg;
        coin_reject_next    = 1'b0;
        sel_error_next      = 1'b0;
        dec_en              = '0;
        case (state_reg)
            COLLECT: begin
                if (cancel) begin
                    // A coin arriving with a cancel loses priority and is returned.
                    coin_reject_next = coin_valid;
                    if (credit_reg != '0) begin
                        change_valid_next = 1'b1;
                        state_next        = CHANGE;
                    end
                end else if (sel_valid) begin
                    coin_reject_next = coin_valid;
                    if (!sel_ok) begin
                        sel_error_next = 1'b1;
                    end else begin
                        credit_next         = CREDIT_W'(AW'(credit_reg) - sel_price);
                        dispense_idx_next   = sel_idx;
                        dispense_valid_next = 1'b1;
                        state_next          = VEND;
                    end
                end else if (coin_valid) begin
                    if (coin_ok) begin
                        credit_next = CREDIT_W'(coin_sum);
                    end else begin
                        coin_reject_next = 1'b1;
                    end
                end
            end
            VEND: begin
                coin_reject_next = coin_valid;
                if (dispense_ready) begin
                    for (int i = 0; i < NUM_PRODUCTS; i++) begin
                        dec_en[i] = (dispense_idx_reg == SEL_W'(i));
                    end
                    dispense_valid_next = 1'b0;
                    if (credit_reg != '0) begin
                        change_valid_next = 1'b1;
                        state_next        = CHANGE;
                    end else begin
                        state_next = COLLECT;
                    end
                end
            end
            CHANGE: begin
                coin_reject_next = coin_valid;
                if (credit_reg == '0) begin
                    change_valid_next = 1'b0;
                    state_next        = COLLECT;
                end else if (change_valid_reg && change_ready) begin
                    credit_next = credit_reg - CREDIT_W'(CHANGE_UNIT);
                    if (credit_reg <= CREDIT_W'(CHANGE_UNIT)) begin
                        credit_next       = '0;
                        change_valid_next = 1'b0;
                        state_next        = COLLECT;
                    end
                end
            end
            default: begin
                state_next          = COLLECT;
                dispense_valid_next = 1'b0;
                change_valid_next   = 1'b0;
            end
        endcase
    end

    // Controller state and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg          <= COLLECT;
            credit_reg         <= '0;
            dispense_valid_reg <= 1'b0;
            dispense_idx_reg   <= '0;
            change_valid_reg   <= 1'b0;
            coin_reject_reg    <= 1'b0;
            sel_error_reg      <= 1'b0;
            busy_reg           <= 1'b0;
        end else begin
            state_reg          <= state_next;
            credit_reg         <= credit_next;
            dispense_valid_reg <= dispense_valid_next;
            dispense_idx_reg   <= dispense_idx_next;
            change_valid_reg   <= change_valid_next;
            coin_reject_reg    <= coin_reject_next;
            sel_error_reg      <= sel_error_next;
            busy_reg           <= (state_next != COLLECT);
        end
    end

    // Per-product stock counter; restock overrides a simultaneous vend and
    // the counter saturates at zero.
    generate
        for (genvar gi = 0; gi < NUM_PRODUCTS; gi++) begin : gen_stock
            // Next stock value for this product.
            always_comb begin
                stock_next[gi] = stock_reg[gi];
                if (restock) begin
                    stock_next[gi] = STOCK_W'(STOCK_INIT);
                end else if (dec_en[gi] && (stock_reg[gi] != '0)) begin
                    stock_next[gi] = stock_reg[gi] - 1'b1;
                end
            end

            // Stock register and its registered empty flag.
            always_ff @(posedge clock) begin
                if (reset) begin
                    stock_reg[gi]       <= STOCK_W'(STOCK_INIT);
                    stock_empty_reg[gi] <= (STOCK_INIT == 0);
                end else begin
                    stock_reg[gi]       <= stock_next[gi];
                    stock_empty_reg[gi] <= (stock_next[gi] == '0);
                end
            end
        end
    endgenerate

    assign dispense_valid = dispense_valid_reg;
    assign dispense_idx   = dispense_idx_reg;
    assign change_valid   = change_valid_reg;
    assign coin_reject    = coin_reject_reg;
    assign sel_error      = sel_error_reg;
    assign credit         = credit_reg;
    assign stock_empty    = stock_empty_reg;
    assign busy           = busy_reg;

endmodule
